i2s_rx: RTL and testbench

- I2S receiver: deserializes a stereo ADC/codec bitstream (ws, sdata) into parallel left/right samples.
- Presents each completed stereo pair with a one-cycle valid strobe.
- Runs entirely in the sclk domain, samples on the rising edge, and sits directly upstream of the I2S transmit path (loopback/effects chain).

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_rx_if.sv | 35 +++
 rtl/i2s_slot_deser.sv | 58 +++++
 rtl/i2s_rx.sv | 128 ++++++++++++
 tb/tb_i2s_rx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default sizing for the I2S receive path.
package i2s_pkg;

    localparam int I2S_WIDTH    = 16;
    localparam int I2S_MAX_SLOT = 32;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } rx_state_t;

    typedef logic [I2S_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_rx_if.sv
// Serial input and parallel sample output bundle of the I2S receiver.
// frame_err exists only when I2SRX_ERR_EN is defined.
interface i2s_rx_if
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH
);

    logic             ws;
    logic             sdata;
    logic [WIDTH-1:0] left_chan;
    logic [WIDTH-1:0] right_chan;
    logic             sample_valid;
    logic             locked;
`ifdef I2SRX_ERR_EN
    logic             frame_err;
`endif

    modport master (
        output ws, sdata,
`ifdef I2SRX_ERR_EN
        input  frame_err,
`endif
        input  left_chan, right_chan, sample_valid, locked
    );

    modport slave (
        input  ws, sdata,
`ifdef I2SRX_ERR_EN
        output frame_err,
`endif
        output left_chan, right_chan, sample_valid, locked
    );

endinterface

// File: rtl/i2s_slot_deser.sv
// Per-slot bit counter and MSB-first deserializer with zero-filled LSBs.
// Short-slot flag is built only with I2SRX_ERR_EN.
module i2s_slot_deser
    import i2s_pkg::*;
#(
    parameter int WIDTH    = I2S_WIDTH,
    parameter int MAX_SLOT = I2S_MAX_SLOT
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             i_edge,
    input  logic             i_clear,
    input  logic             i_sdata,
    output logic [WIDTH-1:0] o_word,
`ifdef I2SRX_ERR_EN
    output logic             o_short,
`endif
    output logic             o_timeout
);

    localparam int CW = $clog2(MAX_SLOT + 2);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] SAT     = CW'(MAX_SLOT + 1);
    localparam logic [CW-1:0] LAST    = CW'(MAX_SLOT);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_kNext;
    logic [WIDTH-1:0] r_shift;
    logic [IW-1:0]    w_idx;
    logic             w_inWord;

    // Bit k lands at position WIDTH-k, so a cleared register is already zero-filled.
    always_comb begin
        w_kNext  = (r_cnt == SAT) ? SAT : r_cnt + CW'(1);
        w_inWord = (w_kNext <= WIDTH_C);
        w_idx    = IW'(WIDTH_C - w_kNext);
    end

    always_ff @(posedge sclk) begin
        if (rst || i_clear || i_edge) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= w_kNext;
            if (w_inWord) begin
                r_shift[w_idx] <= i_sdata;
            end
        end
    end

    assign o_word    = r_shift;
`ifdef I2SRX_ERR_EN
    assign o_short   = i_edge && (r_cnt < WIDTH_C);
`endif
    assign o_timeout = !i_edge && (r_cnt == LAST);

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: frame-lock state machine and stereo output registers.
// Optional frame_err strobe is built when I2SRX_ERR_EN is defined.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH    = I2S_WIDTH,
    parameter int MAX_SLOT = I2S_MAX_SLOT
) (
    input logic      sclk,
    input logic      rst,
    i2s_rx_if.slave  bus
);

    rx_state_t        r_state;
    rx_state_t        w_stateNext;
    logic             r_wsD;
    logic [WIDTH-1:0] r_leftHold;
    logic [WIDTH-1:0] w_leftHoldNext;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] w_leftNext;
    logic [WIDTH-1:0] r_right;
    logic [WIDTH-1:0] w_rightNext;
    logic             r_valid;
    logic             w_validNext;
    logic             w_edge;
    logic             w_fall;
    logic [WIDTH-1:0] w_word;
    logic             w_timeout;
`ifdef I2SRX_ERR_EN
    logic             w_short;
    logic             w_errNext;
    logic             r_err;
`endif

    assign w_edge = bus.ws ^ r_wsD;
    assign w_fall = w_edge & ~bus.ws;

    i2s_slot_deser #(
        .WIDTH    (WIDTH),
        .MAX_SLOT (MAX_SLOT)
    ) u_deser (
        .sclk      (sclk),
        .rst       (rst),
        .i_edge    (w_edge),
        .i_clear   (r_state == SYNC),
        .i_sdata   (bus.sdata),
        .o_word    (w_word),
`ifdef I2SRX_ERR_EN
        .o_short   (w_short),
`endif
        .o_timeout (w_timeout)
    );

    // Timeout and a slot edge are mutually exclusive, so their order here is arbitrary.
    always_comb begin
        w_stateNext    = r_state;
        w_leftHoldNext = r_leftHold;
        w_leftNext     = r_left;
        w_rightNext    = r_right;
        w_validNext    = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_fall) begin
                    w_stateNext = LEFT;
                end
            end
            LEFT: begin
                if (w_timeout) begin
                    w_stateNext    = SYNC;
                    w_leftHoldNext = '0;
                end else if (w_edge) begin
                    w_leftHoldNext = w_word;
                    w_stateNext    = RIGHT;
                end
            end
            RIGHT: begin
                if (w_timeout) begin
                    w_stateNext    = SYNC;
                    w_leftHoldNext = '0;
                end else if (w_edge) begin
                    w_leftNext  = r_leftHold;
                    w_rightNext = w_word;
                    w_validNext = 1'b1;
                    w_stateNext = LEFT;
                end
            end
            default: w_stateNext = SYNC;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state    <= SYNC;
            r_wsD      <= 1'b0;
            r_leftHold <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_wsD      <= bus.ws;
            r_leftHold <= w_leftHoldNext;
            r_left     <= w_leftNext;
            r_right    <= w_rightNext;
            r_valid    <= w_validNext;
        end
    end

`ifdef I2SRX_ERR_EN
    assign w_errNext = (r_state != SYNC) && (w_timeout || w_short);

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_errNext;
        end
    end

    assign bus.frame_err = r_err;
`endif

    assign bus.left_chan    = r_left;
    assign bus.right_chan   = r_right;
    assign bus.sample_valid = r_valid;
    assign bus.locked       = (r_state != SYNC);

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: slot-level reference model feeds event queues,
// a negedge monitor compares every cycle. Checks frame_err when I2SRX_ERR_EN is defined.
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int W  = I2S_WIDTH;
    localparam int MS = I2S_MAX_SLOT;

    typedef struct {
        int      cyc;
        sample_t l;
        sample_t r;
        bit      strobe;
    } outEv_t;

    typedef struct {
        int cyc;
        bit val;
    } lockEv_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    outEv_t  outQ[$];
    lockEv_t lockQ[$];
    int      errQ[$];

    rx_state_t   mState    = SYNC;
    bit          mWs       = 1'b0;
    int          prevLen   = 0;
    logic [31:0] prevBits  = '0;
    sample_t     mLeftHold = '0;

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    i2s_rx_if #(.WIDTH(W)) bus ();

    i2s_rx #(
        .WIDTH    (W),
        .MAX_SLOT (MS)
    ) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // The word of a slot of len cycles is its first W data bits after the edge cycle, zero-filled.
    function automatic sample_t slotWord(input int len, input logic [31:0] bits);
        sample_t w = '0;
        for (int j = 0; j < W; j++) begin
            if (j < len - 1) w[W-1-j] = bits[31-j];
        end
        return w;
    endfunction

    task automatic applyStimulus(input bit wsLevel, input int len, input logic [31:0] bits);
        int      e;
        sample_t word;
        bit      shortSlot;
        @(negedge sclk);
        e = cyc + 1;
        if (wsLevel != mWs) begin
            word      = slotWord(prevLen, prevBits);
            shortSlot = (prevLen - 1) < W;
            case (mState)
                SYNC: begin
                    if (!wsLevel) begin
                        mState = LEFT;
                        lockQ.push_back(lockEv_t'{e, 1'b1});
                    end
                end
                LEFT: begin
                    mLeftHold = word;
                    if (shortSlot) errQ.push_back(e);
                    mState = RIGHT;
                end
                default: begin
                    outQ.push_back(outEv_t'{e, mLeftHold, word, 1'b1});
                    if (shortSlot) errQ.push_back(e);
                    mState = LEFT;
                end
            endcase
        end
        mWs      = wsLevel;
        prevLen  = len;
        prevBits = bits;
        if (mState != SYNC && len >= MS + 2) begin
            errQ.push_back(e + MS + 1);
            lockQ.push_back(lockEv_t'{e + MS + 1, 1'b0});
            mState = SYNC;
        end
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge sclk);
            bus.ws    = wsLevel;
            bus.sdata = (i >= 1 && i <= 32) ? bits[32-i] : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic resetMidSlot();
        int e;
        @(negedge sclk);
        rst = 1'b1;
        e   = cyc + 1;
        outQ.push_back(outEv_t'{e, '0, '0, 1'b0});
        if (mState != SYNC) lockQ.push_back(lockEv_t'{e, 1'b0});
        mState    = SYNC;
        mWs       = 1'b0;
        mLeftHold = '0;
        @(negedge sclk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        sample_t expL    = '0;
        sample_t expR    = '0;
        bit      expLock = 1'b0;
        bit      expStrobe;
        bit      expErr;
        outEv_t  ev;
        forever begin
            @(negedge sclk);
            expStrobe = 1'b0;
            if (outQ.size() > 0 && outQ[0].cyc == cyc) begin
                ev        = outQ.pop_front();
                expL      = ev.l;
                expR      = ev.r;
                expStrobe = ev.strobe;
            end
            if (lockQ.size() > 0 && lockQ[0].cyc == cyc) begin
                expLock = lockQ.pop_front().val;
            end
            expErr = (errQ.size() > 0 && errQ[0] == cyc);
            if (expErr) void'(errQ.pop_front());
            checkOutput("sample_valid", 32'(bus.sample_valid), 32'(expStrobe));
            checkOutput("left_chan",    32'(bus.left_chan),    32'(expL));
            checkOutput("right_chan",   32'(bus.right_chan),   32'(expR));
            checkOutput("locked",       32'(bus.locked),       32'(expLock));
`ifdef I2SRX_ERR_EN
            checkOutput("frame_err",    32'(bus.frame_err),    32'(expErr));
`endif
        end
    end

    initial begin : stimulus
        int r;
        int len;
        bus.ws    = 1'b0;
        bus.sdata = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge sclk);
        rst = 1'b0;

        // Partial left slot while unlocked, then lock and stream 17-cycle slots.
        applyStimulus(1'b0, 9,  $urandom());
        applyStimulus(1'b1, 17, $urandom());
        applyStimulus(1'b0, 17, 32'hA5C3_0000);
        applyStimulus(1'b1, 17, 32'h1234_0000);

        for (int f = 0; f < 4; f++) begin
            applyStimulus(1'b0, 32, 32'h8001_0000);
            applyStimulus(1'b1, 32, 32'h7FFE_0000);
        end

        // 12-bit left slot, then a 40-cycle left slot that loses lock.
        applyStimulus(1'b0, 13, 32'hABC0_0000);
        applyStimulus(1'b1, 17, $urandom());
        applyStimulus(1'b0, 40, $urandom());
        applyStimulus(1'b1, 17, $urandom());
        applyStimulus(1'b0, 17, $urandom());
        applyStimulus(1'b1, 17, $urandom());
        applyStimulus(1'b0, 17, $urandom());

        applyStimulus(1'b1, 8, $urandom());
        resetMidSlot();

        for (int s = 0; s < 40; s++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      len = $urandom_range(17, 33);
            else if (r < 8) len = $urandom_range(2, 16);
            else            len = $urandom_range(34, 45);
            applyStimulus(!mWs, len, $urandom());
        end

        applyStimulus(!mWs, 5, $urandom());
        repeat (3) @(negedge sclk);

        checkOutput("outQ_drained",  32'(outQ.size()),  32'd0);
        checkOutput("lockQ_drained", 32'(lockQ.size()), 32'd0);
`ifdef I2SRX_ERR_EN
        checkOutput("errQ_drained",  32'(errQ.size()),  32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
